// File: rtl/led_pattern_driver_pkg.sv
// Shared mode encodings, LED index constants and small helpers for the LED
// pattern driver and its per-LED channel.
package led_pattern_driver_pkg;

  typedef enum logic [2:0] {
    MODE_OFF        = 3'd0,
    MODE_ON         = 3'd1,
    MODE_BLINK_SLOW = 3'd2,
    MODE_BLINK_FAST = 3'd3,
    MODE_ONESHOT    = 3'd4
  } mode_e;

  localparam int NUM_LEDS = 4;

  localparam logic [1:0] LED_1_IDX = 2'd0;
  localparam logic [1:0] LED_2_IDX = 2'd1;
  localparam logic [1:0] LED_3_IDX = 2'd2;
  localparam logic [1:0] LED_4_IDX = 2'd3;

  // Encodings 5..7 are reserved: accepted on the bus but ignored by a channel.
  function automatic logic is_valid_mode(input logic [2:0] mode);
    return mode <= 3'd4;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_pattern_driver_led_channel.sv
// One LED channel: holds its mode, a tick counter and the registered LED drive.
// A command on apply always takes priority over a coincident tick.
module led_channel
  import led_pattern_driver_pkg::*;
#(
  parameter int SLOW_HALF_TICKS = 250,
  parameter int FAST_HALF_TICKS = 62,
  parameter int PULSE_TICKS     = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       apply,
  input  logic [2:0] mode,
  output logic       led
);

  localparam int MAX_TERM = max3(SLOW_HALF_TICKS - 1, FAST_HALF_TICKS - 1, PULSE_TICKS - 1);
  localparam int CNT_W    = (MAX_TERM < 1) ? 1 : $clog2(MAX_TERM + 1);

  localparam logic [CNT_W-1:0] SLOW_TERM  = CNT_W'(SLOW_HALF_TICKS - 1);
  localparam logic [CNT_W-1:0] FAST_TERM  = CNT_W'(FAST_HALF_TICKS - 1);
  localparam logic [CNT_W-1:0] PULSE_TERM = CNT_W'(PULSE_TICKS - 1);

  mode_e            mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_term;

  assign half_term = (mode_q == MODE_BLINK_SLOW) ? SLOW_TERM : FAST_TERM;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_OFF;
      cnt_q  <= '0;
      led    <= 1'b0;
    end else if (apply && is_valid_mode(mode)) begin
      // Re-issuing the current mode lands here too, restarting its phase.
      mode_q <= mode_e'(mode);
      cnt_q  <= '0;
      led    <= (mode_e'(mode) != MODE_OFF);
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK_SLOW, MODE_BLINK_FAST: begin
          if (cnt_q == half_term) begin
            led   <= ~led;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MODE_ONESHOT: begin
          if (cnt_q == PULSE_TERM) begin
            led    <= 1'b0;
            mode_q <= MODE_OFF;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Four-LED pattern driver: shared tick prescaler, valid/ready command intake
// with a one-entry holding register, and one led_channel per LED pin.
module led_pattern_driver
  import led_pattern_driver_pkg::*;
#(
  parameter int CLKS_PER_TICK   = 25000,
  parameter int SLOW_HALF_TICKS = 250,
  parameter int FAST_HALF_TICKS = 62,
  parameter int PULSE_TICKS     = 200
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Cmd_Valid,
  input  logic [1:0] i_Cmd_Idx,
  input  logic [2:0] i_Cmd_Mode,
  output logic       o_Cmd_Ready,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4
);

  localparam int PRESC_W = $clog2(CLKS_PER_TICK);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_TICK - 1);

  logic [PRESC_W-1:0] presc_q;
  logic               tick;
  logic               xfer;

  logic               vld_p0;
  logic [1:0]         cmd_idx_p0;
  logic [2:0]         cmd_mode_p0;

  logic [NUM_LEDS-1:0] apply_ch;
  logic [NUM_LEDS-1:0] leds;

  assign tick = (presc_q == PRESC_LAST);
  assign xfer = i_Cmd_Valid && o_Cmd_Ready;

  // Stage p0: capture the command; ready drops for the following apply cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      presc_q     <= '0;
      o_Cmd_Ready <= 1'b0;
      vld_p0      <= 1'b0;
      cmd_idx_p0  <= '0;
      cmd_mode_p0 <= '0;
    end else begin
      presc_q     <= tick ? '0 : presc_q + 1'b1;
      o_Cmd_Ready <= !xfer;
      vld_p0      <= xfer;
      if (xfer) begin
        cmd_idx_p0  <= i_Cmd_Idx;
        cmd_mode_p0 <= i_Cmd_Mode;
      end
    end
  end

  // Stage p1: the held command is applied to its target channel only.
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    assign apply_ch[g] = vld_p0 && (cmd_idx_p0 == 2'(g));

    led_channel #(
      .SLOW_HALF_TICKS(SLOW_HALF_TICKS),
      .FAST_HALF_TICKS(FAST_HALF_TICKS),
      .PULSE_TICKS    (PULSE_TICKS)
    ) u_ch (
      .clk  (i_Clk),
      .reset(i_Reset),
      .tick (tick),
      .apply(apply_ch[g]),
      .mode (cmd_mode_p0),
      .led  (leds[g])
    );
  end

  assign o_LED_1 = leds[LED_1_IDX];
  assign o_LED_2 = leds[LED_2_IDX];
  assign o_LED_3 = leds[LED_3_IDX];
  assign o_LED_4 = leds[LED_4_IDX];

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: a tick-count model checked every cycle plus
// directed scenarios with hand-computed timings.
module tb_led_pattern_driver;

  localparam int TPC   = 4;
  localparam int SLOW  = 3;
  localparam int FAST  = 1;
  localparam int PULSE = 5;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [1:0] idx;
  logic [2:0] mode;
  logic       ready;
  logic       led1, led2, led3, led4;
  logic [3:0] led_v;

  assign led_v = {led4, led3, led2, led1};

  led_pattern_driver #(
    .CLKS_PER_TICK  (TPC),
    .SLOW_HALF_TICKS(SLOW),
    .FAST_HALF_TICKS(FAST),
    .PULSE_TICKS    (PULSE)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_Cmd_Valid(valid),
    .i_Cmd_Idx  (idx),
    .i_Cmd_Mode (mode),
    .o_Cmd_Ready(ready),
    .o_LED_1    (led1),
    .o_LED_2    (led2),
    .o_LED_3    (led3),
    .o_LED_4    (led4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Model: edges counted since reset release; a tick falls on every edge n
  // with n % TPC == 0. Each channel remembers its mode and apply edge.
  int n = 0;
  int m_mode[4];
  int m_start[4];
  bit ready_e = 0;
  bit pend = 0;
  int pend_idx, pend_mode;
  int xfer_prev = 0, xfer_last = 0;

  always @(posedge clk) begin
    if (rst) begin
      n       <= 0;
      ready_e <= 0;
      pend    <= 0;
      for (int i = 0; i < 4; i++) begin
        m_mode[i]  <= 0;
        m_start[i] <= 0;
      end
    end else begin
      n <= n + 1;
      if (pend && pend_mode <= 4) begin
        m_mode[pend_idx]  <= pend_mode;
        m_start[pend_idx] <= n + 1;
      end
      pend      <= valid && ready_e;
      pend_idx  <= int'(idx);
      pend_mode <= int'(mode);
      ready_e   <= !(valid && ready_e);
      if (valid && ready_e) begin
        xfer_prev <= xfer_last;
        xfer_last <= n + 1;
      end
    end
  end

  function automatic bit exp_led(input int m, input int s, input int now);
    int t;
    t = now / TPC - s / TPC;
    case (m)
      1:       return 1'b1;
      2:       return ((t / SLOW) % 2) == 0;
      3:       return ((t / FAST) % 2) == 0;
      4:       return t < PULSE;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (led_v[i] !== exp_led(m_mode[i], m_start[i], n)) begin
          errors++;
          $display("FAIL model_led%0d at edge %0d: got %b want %b", i + 1, n, led_v[i],
                   exp_led(m_mode[i], m_start[i], n));
        end
      end
      checks++;
      if (ready !== ready_e) begin
        errors++;
        $display("FAIL model_ready at edge %0d: got %b want %b", n, ready, ready_e);
      end
    end
  end

  int led2_cnt = 0;
  always @(negedge clk) if (led2 === 1'b1) led2_cnt++;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] i, input logic [2:0] m, input bit hold);
    int w;
    valid = 1'b1;
    idx   = i;
    mode  = m;
    w     = 0;
    while (ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk("send_timeout", w, 0);
    @(negedge clk);
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_phase(input int r);
    int w;
    w = 0;
    while ((n % TPC) != r && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (w >= 10) chk("phase_timeout", w, 0);
  endtask

  task automatic run_len(input int ch, input bit val, output int len);
    int w;
    w   = 0;
    len = 0;
    while (led_v[ch] !== val && w < 100) begin
      @(negedge clk);
      w++;
    end
    while (led_v[ch] === val && len < 100) begin
      @(negedge clk);
      len++;
    end
  endtask

  initial begin
    int len;
    int cnt;
    rst   = 1'b1;
    valid = 1'b0;
    idx   = '0;
    mode  = '0;

    // Reset held for three clocks
    @(negedge clk);
    chk_en = 1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready", int'(ready), 0);
      chk("reset_leds", int'(led_v), 0);
      if (i < 2) @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", int'(ready), 1);
    chk("leds_after_release", int'(led_v), 0);
    repeat (2) @(negedge clk);

    // ON to LED_3
    send(2'd2, 3'd1, 1'b0);
    chk("on_ready_low", int'(ready), 0);
    chk("on_led3_not_yet", int'(led3), 0);
    @(negedge clk);
    chk("on_led3", int'(led3), 1);
    chk("on_ready_back", int'(ready), 1);
    chk("on_others", int'({led4, led2, led1}), 0);

    // Slow blink on LED_1, applied on a tick edge so every half lasts 3 ticks
    wait_phase(2);
    send(2'd0, 3'd2, 1'b0);
    run_len(0, 1'b1, len);
    chk("slow_high1", len, 12);
    run_len(0, 1'b0, len);
    chk("slow_low1", len, 12);
    run_len(0, 1'b1, len);
    chk("slow_high2", len, 12);

    // One-shot on LED_2 retriggered 3 ticks later: 8 ticks high in total
    wait_phase(2);
    led2_cnt = 0;
    send(2'd1, 3'd4, 1'b0);
    repeat (11) @(negedge clk);
    send(2'd1, 3'd4, 1'b0);
    repeat (40) @(negedge clk);
    chk("oneshot_high_clks", led2_cnt, 32);
    chk("oneshot_ends_off", int'(led2), 0);

    // Back-to-back with valid held; reserved mode 6 leaves LED_4 alone
    send(2'd3, 3'd1, 1'b1);
    send(2'd3, 3'd6, 1'b0);
    chk("b2b_spacing", xfer_last - xfer_prev, 2);
    repeat (3) @(negedge clk);
    chk("reserved_led4_kept", int'(led4), 1);

    // All four active, then reset mid-pattern
    send(2'd1, 3'd3, 1'b0);
    send(2'd2, 3'd2, 1'b0);
    send(2'd3, 3'd3, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_reset_led3", int'(led3), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_leds", int'(led_v), 0);
    chk("midreset_ready", int'(ready), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (led_v != 4'b0000) cnt++;
    end
    chk("no_resume_after_reset", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
